// File: rtl/fsm_sched_pkg.sv
// rtl/fsm_sched_pkg.sv - state encoding and round-robin grant helper for fsm_serial_sched
package fsm_sched_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLR   = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // rr is the id served last; on a tie the other requester wins.
  function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic rr);
    logic [1:0] g;
    g = 2'b00;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = rr ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/fsm_sched_rr_arb.sv
// rtl/fsm_sched_rr_arb.sv - two-way round-robin arbiter with last-served pointer
module fsm_sched_rr_arb
  import fsm_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       grant_id,
  output logic       accept
);

  logic rr_q;
  logic rr_d;

  always_comb begin
    grant    = en ? rr_grant(valid, rr_q) : 2'b00;
    grant_id = grant[1];
    accept   = |grant;
    rr_d     = accept ? grant_id : rr_q;
  end

  // Pointer starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b1;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/fsm_serial_sched.sv
// rtl/fsm_serial_sched.sv - schedules a bit-serial FSM between two requesters
// Optional rsp_ones output enabled by FSM_SCHED_ZCOUNT_EN.
module fsm_serial_sched
  import fsm_sched_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_x,
  input  logic [2*WIDTH-1:0] req_y,
  output logic               fsm_rst,
  output logic               x,
  output logic               y,
  input  logic               z,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_z,
`ifdef FSM_SCHED_ZCOUNT_EN
  output logic [$clog2(WIDTH+1)-1:0] rsp_ones,
`endif
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int OW = $clog2(WIDTH+1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] wx_q, wx_d;
  logic [WIDTH-1:0] wy_q, wy_d;
  logic             id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_m1;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             x_q, x_d;
  logic             y_q, y_d;
  logic             fsm_rst_q, fsm_rst_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_z_q, rsp_z_d;
`ifdef FSM_SCHED_ZCOUNT_EN
  logic [OW-1:0]    ones_q, ones_d;
  logic [OW-1:0]    rsp_ones_q, rsp_ones_d;
`endif

  logic       grant_id;
  logic       accept;
  logic [1:0] grant;

  fsm_sched_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == IDLE),
    .valid    (req_valid),
    .grant    (grant),
    .grant_id (grant_id),
    .accept   (accept)
  );

  assign cnt_m1 = cnt_q - CW'(1);

  always_comb begin
    state_d     = state_q;
    wx_d        = wx_q;
    wy_d        = wy_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    x_d         = x_q;
    y_d         = y_q;
    fsm_rst_d   = fsm_rst_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_z_d     = rsp_z_q;
`ifdef FSM_SCHED_ZCOUNT_EN
    ones_d      = ones_q;
    rsp_ones_d  = rsp_ones_q;
`endif
    case (state_q)
      IDLE: begin
        fsm_rst_d = 1'b1;
        x_d       = 1'b0;
        y_d       = 1'b0;
        if (accept) begin
          wx_d    = grant_id ? req_x[2*WIDTH-1:WIDTH] : req_x[WIDTH-1:0];
          wy_d    = grant_id ? req_y[2*WIDTH-1:WIDTH] : req_y[WIDTH-1:0];
          id_d    = grant_id;
          state_d = CLR;
        end
      end
      CLR: begin
        // Preload the MSB so x/y are registered for the whole first shift cycle.
        state_d   = SHIFT;
        cnt_d     = CW'(WIDTH-1);
        x_d       = wx_q[WIDTH-1];
        y_d       = wy_q[WIDTH-1];
        fsm_rst_d = 1'b0;
        sh_d      = '0;
`ifdef FSM_SCHED_ZCOUNT_EN
        ones_d    = '0;
`endif
      end
      SHIFT: begin
        sh_d = {sh_q[WIDTH-2:0], z};
`ifdef FSM_SCHED_ZCOUNT_EN
        ones_d = ones_q + OW'(z);
`endif
        if (cnt_q == '0) begin
          state_d     = DONE;
          x_d         = 1'b0;
          y_d         = 1'b0;
          fsm_rst_d   = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_z_d     = sh_d;
`ifdef FSM_SCHED_ZCOUNT_EN
          rsp_ones_d  = ones_d;
`endif
        end else begin
          cnt_d = cnt_m1;
          x_d   = wx_q[cnt_m1];
          y_d   = wy_q[cnt_m1];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wx_q        <= '0;
      wy_q        <= '0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      sh_q        <= '0;
      x_q         <= 1'b0;
      y_q         <= 1'b0;
      fsm_rst_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_z_q     <= '0;
`ifdef FSM_SCHED_ZCOUNT_EN
      ones_q      <= '0;
      rsp_ones_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wx_q        <= wx_d;
      wy_q        <= wy_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fsm_rst_q   <= fsm_rst_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_z_q     <= rsp_z_d;
`ifdef FSM_SCHED_ZCOUNT_EN
      ones_q      <= ones_d;
      rsp_ones_q  <= rsp_ones_d;
`endif
    end
  end

  assign req_ready = grant;
  assign fsm_rst   = fsm_rst_q;
  assign x         = x_q;
  assign y         = y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;
  assign busy      = (state_q != IDLE);
`ifdef FSM_SCHED_ZCOUNT_EN
  assign rsp_ones  = rsp_ones_q;
`endif

endmodule

// File: tb/tb_fsm_serial_sched.sv
// tb/tb_fsm_serial_sched.sv - self-checking bench for fsm_serial_sched
module tb_fsm_serial_sched;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_x, req_y;
  logic           fsm_rst, x, y, z;
  logic           rsp_valid, rsp_id;
  logic [W-1:0]   rsp_z;
  logic           busy;
`ifdef FSM_SCHED_ZCOUNT_EN
  logic [4:0]     rsp_ones;
`endif

  always #5 clk = ~clk;

  fsm_serial_sched #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .fsm_rst   (fsm_rst),
    .x         (x),
    .y         (y),
    .z         (z),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z),
`ifdef FSM_SCHED_ZCOUNT_EN
    .rsp_ones  (rsp_ones),
`endif
    .busy      (busy)
  );

  // Downstream FSM: Mealy running parity of x^y (mode 0) or plain loopback of x (mode 1).
  logic z_mode = 1'b0;
  logic s = 1'b0;
  assign z = z_mode ? x : (s ^ x ^ y);
  always @(posedge clk) s <= fsm_rst ? 1'b0 : z;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int           due;
    logic         id;
    logic [W-1:0] zw;
    int           ones;
  } rsp_t;

  rsp_t         rq[$];
  int           served[$];
  int           cyc = 0;
  int           next_free = 0;
  int           last_acc = -1000;
  logic         last_id = 1'b1;
  logic [W-1:0] cur_x = '0, cur_y = '0;
  logic [W-1:0] held_z = '0;
  logic         held_id = 1'b0;
  int           held_ones = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode);
    logic [W-1:0] r;
    logic p;
    p = 1'b0;
    r = '0;
    for (int i = W-1; i >= 0; i--) begin
      p    = p ^ a[i] ^ b[i];
      r[i] = mode ? a[i] : p;
    end
    return r;
  endfunction

  function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  // One cycle: inputs already driven at the negedge; compare, update model, advance.
  task automatic step();
    logic [1:0]   g;
    logic         rv;
    logic         in_shift;
    int           k;
    int           id;
    rsp_t         e;
    #1;
    if (rst) begin
      rq.delete();
      next_free = cyc + 1;
      last_acc  = -1000;
      last_id   = 1'b1;
      held_z    = '0;
      held_id   = 1'b0;
      held_ones = 0;
    end else begin
      g = (cyc >= next_free) ? exp_grant(req_valid, last_id) : 2'b00;
      check("req_ready", {30'd0, req_ready}, {30'd0, g});
      check("busy", {31'd0, busy}, {31'd0, (cyc < next_free)});
      rv = (rq.size() > 0) && (rq[0].due == cyc);
      if (rv) begin
        held_z    = rq[0].zw;
        held_id   = rq[0].id;
        held_ones = rq[0].ones;
        void'(rq.pop_front());
      end
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, rv});
      check("rsp_z", {16'd0, rsp_z}, {16'd0, held_z});
      check("rsp_id", {31'd0, rsp_id}, {31'd0, held_id});
`ifdef FSM_SCHED_ZCOUNT_EN
      if (rv) check("rsp_ones", {27'd0, rsp_ones}, held_ones);
`endif
      k = cyc - (last_acc + 2);
      in_shift = (k >= 0) && (k < W);
      check("fsm_rst", {31'd0, fsm_rst}, {31'd0, !in_shift});
      check("x_bit", {31'd0, x}, {31'd0, in_shift ? cur_x[W-1-k] : 1'b0});
      check("y_bit", {31'd0, y}, {31'd0, in_shift ? cur_y[W-1-k] : 1'b0});
      if (g != 2'b00) begin
        id      = g[1] ? 1 : 0;
        cur_x   = req_x[id*W +: W];
        cur_y   = req_y[id*W +: W];
        e.due   = cyc + W + 2;
        e.id    = g[1];
        e.zw    = golden(cur_x, cur_y, z_mode);
        e.ones  = $countones(e.zw);
        rq.push_back(e);
        last_id   = g[1];
        next_free = cyc + W + 3;
        last_acc  = cyc;
        served.push_back(id);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    step();
    rst = 1'b0;
  endtask

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_x[id*W +: W] = a;
    req_y[id*W +: W] = b;
  endtask

  typedef struct {
    logic [1:0] v;
    logic [1:0] g;
  } vec_t;

  vec_t tbl[10];
  int   acc0;

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    req_x = '0;
    req_y = '0;
    @(negedge clk);
    do_reset();

    // Explicit reset-state checks before any traffic.
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_fsm_rst", {31'd0, fsm_rst}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_z", {16'd0, rsp_z}, 32'd0);
    check("reset_xy", {30'd0, x, y}, 32'd0);
    @(negedge clk);
    cyc++;

    // Arbitration table from reset: pointer starts at 1.
    tbl[0] = '{2'b11, 2'b01}; tbl[1] = '{2'b11, 2'b10};
    tbl[2] = '{2'b10, 2'b10}; tbl[3] = '{2'b10, 2'b10};
    tbl[4] = '{2'b11, 2'b01}; tbl[5] = '{2'b01, 2'b01};
    tbl[6] = '{2'b11, 2'b10}; tbl[7] = '{2'b00, 2'b00};
    tbl[8] = '{2'b01, 2'b01}; tbl[9] = '{2'b11, 2'b10};
    for (int i = 0; i < 10; i++) begin
      set_req(0, W'($urandom), W'($urandom));
      set_req(1, W'($urandom), W'($urandom));
      req_valid = tbl[i].v;
      #1;
      check("tbl_grant", {30'd0, req_ready}, {30'd0, tbl[i].g});
      step();
      req_valid = 2'b00;
      if (tbl[i].v != 2'b00) repeat (W + 2) step();
    end

    // Single request on req0 with known words.
    do_reset();
    z_mode = 1'b0;
    set_req(0, 16'h3BC7, 16'h3BF8);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    repeat (W + 3) step();

    // Loopback: z follows x.
    z_mode = 1'b1;
    set_req(0, 16'hA5A5, 16'h0F0F);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    repeat (W + 2) step();
    check("loopback_rsp_z", {16'd0, rsp_z}, 32'h0000A5A5);
`ifdef FSM_SCHED_ZCOUNT_EN
    check("loopback_ones", {27'd0, rsp_ones}, 32'd8);
`endif
    repeat (2) step();
    z_mode = 1'b0;

    // Fairness: both held valid, grants must alternate 0,1,0,1.
    do_reset();
    served.delete();
    set_req(0, 16'h1234, 16'h8001);
    set_req(1, 16'hFFFF, 16'h00FF);
    req_valid = 2'b11;
    repeat (4 * (W + 3)) step();
    req_valid = 2'b00;
    check("fair_count", served.size(), 32'd4);
    for (int i = 0; i < 4 && i < served.size(); i++) check("fair_order", served[i], i % 2);
    repeat (W + 3) step();

    // Reset while shifting bit 7: no response, then a fresh request completes.
    do_reset();
    set_req(0, 16'hC3A1, 16'h5E77);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_fsm_rst", {31'd0, fsm_rst}, 32'd1);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    cyc++;
    repeat (W + 4) step();
    set_req(1, 16'h7E81, 16'h1111);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    repeat (W + 3) step();

    // Busy gating: req1 raised during req0's shift is taken on the first idle cycle.
    do_reset();
    served.delete();
    set_req(0, 16'h0BAD, 16'hF00D);
    set_req(1, 16'hBEEF, 16'h4321);
    req_valid = 2'b01;
    step();
    acc0 = last_acc;
    req_valid = 2'b00;
    repeat (5) step();
    req_valid = 2'b10;
    for (int i = 0; i < W + 4 && served.size() < 2; i++) step();
    req_valid = 2'b00;
    check("gate_served", served.size(), 32'd2);
    check("gate_accept_cycle", last_acc, acc0 + W + 3);
    repeat (W + 3) step();

    // Randomized traffic with occasional reset.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_x = {W'($urandom), W'($urandom)};
      req_y = {W'($urandom), W'($urandom)};
      rst = ($urandom_range(0, 299) == 0);
      step();
      rst = 1'b0;
    end
    req_valid = 2'b00;
    repeat (W + 3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
